// File: rtl/fp_unit_arbiter.sv
// fp_unit_arbiter: round-robin, credit-gated sharing of one fixed-latency FP add/sub unit.
// Ports: clk, rst_n (sync, active-low); req_valid/ready/a/b/op per requester;
//        unit_valid/a/b/op to the shared unit, unit_result back;
//        rsp_valid/ready/data/id from the result FIFO.
module fp_unit_arbiter #(
    parameter int EXP_SIZE    = 8,
    parameter int MANTIS_SIZE = 23,
    parameter int N_REQ       = 4,
    parameter int LATENCY     = 3,
    parameter int FIFO_DEPTH  = 5,
    localparam int W          = 1 + EXP_SIZE + MANTIS_SIZE,
    localparam int IDW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ-1:0]   req_op,
    output logic               unit_valid,
    output logic [W-1:0]       unit_a,
    output logic [W-1:0]       unit_b,
    output logic               unit_op,
    input  logic [W-1:0]       unit_result,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [W-1:0]       rsp_data,
    output logic [IDW-1:0]     rsp_id
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [IDW-1:0] rr;
    logic [IDW-1:0] winner;
    logic           found;
    logic           allow;
    logic           accept;
    logic           pop;
    logic [CW-1:0]  outstanding;
    logic [IDW-1:0] unit_id;

    logic [LATENCY-1:0] tag_v;
    logic [IDW-1:0]     tag_id [LATENCY];

    logic [W-1:0]   mem_data [FIFO_DEPTH];
    logic [IDW-1:0] mem_id   [FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic           wr_en;
    logic           full;

    // Round-robin search starting at rr, wrapping at N_REQ-1.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    assign pop   = rsp_valid & rsp_ready;
    // A pop in the same cycle frees a credit, so issue can proceed
    // even when every credit is held.
    assign allow  = (outstanding < CW'(FIFO_DEPTH)) | pop;
    assign accept = rst_n & found & allow;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = accept && (winner == IDW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr          <= '0;
            outstanding <= '0;
            unit_valid  <= 1'b0;
            unit_a      <= '0;
            unit_b      <= '0;
            unit_op     <= 1'b0;
            unit_id     <= '0;
        end else begin
            unit_valid <= accept;
            if (accept) begin
                rr      <= (winner == IDW'(N_REQ - 1)) ? '0 : winner + 1'b1;
                unit_a  <= req_a[int'(winner)*W +: W];
                unit_b  <= req_b[int'(winner)*W +: W];
                unit_op <= req_op[winner];
                unit_id <= winner;
            end
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Tag pipeline follows unit_valid so stage LATENCY lines up with unit_result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_v <= '0;
        end else begin
            tag_v[0] <= unit_valid;
            for (int k = 1; k < LATENCY; k++) tag_v[k] <= tag_v[k-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_id[0] <= unit_id;
        for (int k = 1; k < LATENCY; k++) tag_id[k] <= tag_id[k-1];
    end

    assign wr_en     = tag_v[LATENCY-1];
    assign full      = (count == CW'(FIFO_DEPTH));
    assign rsp_valid = (count != '0);
    assign rsp_data  = rsp_valid ? mem_data[rd_ptr] : '0;
    assign rsp_id    = rsp_valid ? mem_id[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_ptr] <= unit_result;
            mem_id[wr_ptr]   <= tag_id[LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Credits make this unreachable; it guards against a broken credit path.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && full && !pop));

endmodule

// File: doc/fp_unit_arbiter.md
# fp_unit_arbiter

Shares one fixed-latency floating-point arithmetic unit (unpack → align → add/sub → normalize) between N_REQ independent requesters. The block runs a round-robin arbiter and registers the operands into the shared unit. It tracks the requester ID of every in-flight operation through a tag pipeline, then buffers results in an output FIFO with requester IDs attached. Issue is credit-gated so the non-stallable unit can never overflow the result FIFO.

## Interface
- EXP_SIZE, default `EXP_SIZE` (configuration.v), exponent width.
- MANTIS_SIZE, default `MANTIS_SIZE` (configuration.v), stored mantissa width.
- N_REQ, default 4, number of requesters (≥2).
- LATENCY, default 3, shared unit latency in cycles, from operand capture to result (≥1).
- FIFO_DEPTH, default 5, result FIFO entries and issue credits (≥1; LATENCY+2 gives full throughput).
- Widths: W = 1+EXP_SIZE+MANTIS_SIZE; IDW = clog2(N_REQ).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  N_REQ  per-requester operation request.
- req_ready  out  N_REQ  per-requester accept; at most one bit set.
- req_a  in  N_REQ*W  operand A; slice i belongs to requester i.
- req_b  in  N_REQ*W  operand B; slice i belongs to requester i.
- req_op  in  N_REQ  per-requester opcode (0 add, 1 sub).
- unit_valid  out  1  operand strobe to the shared unit.
- unit_a, unit_b  out  W  registered operands.
- unit_op  out  1  registered opcode.
- unit_result  in  W  unit result, valid exactly LATENCY cycles after unit_valid.
- rsp_valid  out  1  FIFO head is valid.
- rsp_ready  in  1  consumer pops the head.
- rsp_data  out  W  result at the FIFO head.
- rsp_id  out  IDW  ID of the requester that issued the head result.

## Operation
- Credit counter `outstanding` (0..FIFO_DEPTH): counts accepted requests not yet popped. Issue is allowed only when outstanding < FIFO_DEPTH.
- Accept and pop in the same cycle leave `outstanding` unchanged.
- Arbiter: round-robin pointer `rr`. The search runs rr, rr+1, …, wrapping at N_REQ−1 → 0. The first requester with req_valid=1 wins if issue is allowed.
- req_ready[winner]=1 combinationally in that cycle, so ready depends on valid. Handshake = req_valid[i] & req_ready[i].
- On accept: rr ← winner+1 (mod N_REQ). rr is unchanged when nothing is accepted.
- On accept: unit_a/unit_b/unit_op ← the winner's slices, and unit_valid ← 1 the next cycle. With no accept, unit_valid ← 0 and the operand registers hold.
- Tag pipeline: LATENCY stages of {valid, id}, entered in parallel with unit_valid. When the stage-LATENCY output is valid, {unit_result, id} is written into the FIFO at that edge.
- FIFO: depth FIFO_DEPTH. Head drives rsp_data/rsp_id; rsp_valid = not empty; pop on rsp_valid & rsp_ready.
- Write and pop in the same cycle are both honored, including when the FIFO is full.
- Overflow is impossible by construction. An implementation assertion flags a write to a full FIFO without a concurrent pop.
- Pop on empty (rsp_ready with rsp_valid=0) is ignored.
- Operand values and opcode pass through unmodified. Special-value handling (zero/inf/NaN/denormal) belongs to the unit.

## Timing
- Request accepted at edge of cycle t → unit_valid=1 in cycle t+1 → unit_result sampled at end of cycle t+1+LATENCY → earliest rsp_valid in cycle t+2+LATENCY. Minimum latency LATENCY+2.
- Throughput: one accept per cycle while credits remain.
- Reset (rst_n=0 at a rising edge) sets:
  - req_ready=0, unit_valid=0, unit_a=unit_b=0, unit_op=0;
  - rsp_valid=0, rsp_data=0, rsp_id=0;
  - rr=0, outstanding=0, tag pipeline invalid, FIFO empty.
- Reset mid-operation discards all in-flight results; unit_result is ignored until new issues mature.
- req_ready stays 0 during reset cycles.

## Test plan
(EXP_SIZE=8, MANTIS_SIZE=23, defaults otherwise; unit model = 3-cycle pipelined adder.)
- Single request: req0 valid with a=32'h3F800000, b=32'h40000000, op=0, accepted cycle 0 → unit_valid in cycle 1; rsp_valid in cycle 5 with rsp_data=32'h40400000 and rsp_id=0.
- All four requesters valid continuously from reset → grants in order 0,1,2,3,0,…; rsp_id sequence matches; rr wraps 3→0.
- rsp_ready=0 with continuous requests → exactly 5 accepts, then all req_ready=0. Raising rsp_ready for one cycle → one pop and one new accept in that same cycle.
- FIFO full with a write arriving and rsp_ready=1 in the same cycle → no data loss, occupancy stays 5, order preserved.
- Reset asserted while 3 operations are in flight → following cycle shows rsp_valid=0 and outstanding=0. No stale result appears afterwards, and the next grant goes to requester 0.
- Only req2 valid after a grant to req3 (rr=0) → req2 granted the same cycle, rr becomes 3.
